// File: rtl/c1_bus_pkg.sv
// c1_bus_pkg: shared definitions for the C1 shared-bus master and its drivers.
//   - C1 command / response codes carried on ctrl
//   - master FSM state encoding
//   - default bus field widths
//   - is_write() helper for command decode
package c1_bus_pkg;

  localparam int C1_CMD_W    = 3;
  localparam int C1_TAGSET_W = 14;
  localparam int C1_OFFSET_W = 4;
  localparam int C1_DATA_W   = 16;

  localparam logic [C1_CMD_W-1:0] C1_NOP             = 3'd0;
  localparam logic [C1_CMD_W-1:0] C1_READ8           = 3'd1;
  localparam logic [C1_CMD_W-1:0] C1_READ16          = 3'd2;
  localparam logic [C1_CMD_W-1:0] C1_READ32          = 3'd3;
  localparam logic [C1_CMD_W-1:0] C1_INVALIDATE_LINE = 3'd4;
  localparam logic [C1_CMD_W-1:0] C1_WRITE8          = 3'd5;
  localparam logic [C1_CMD_W-1:0] C1_WRITE16         = 3'd6;
  localparam logic [C1_CMD_W-1:0] C1_WRITE32         = 3'd7;
  // The cache answers with the same code as WRITE32; the master only looks
  // for it in WAIT, after it has released ctrl.
  localparam logic [C1_CMD_W-1:0] C1_RESPONSE        = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD1,
    ST_CMD2,
    ST_TURN,
    ST_WAIT,
    ST_RD2,
    ST_DONE
  } c1_state_e;

  function automatic logic is_write(input logic [C1_CMD_W-1:0] cmd);
    return (cmd == C1_WRITE8) || (cmd == C1_WRITE16) || (cmd == C1_WRITE32);
  endfunction

endpackage

// File: rtl/c1_bus_drv.sv
// c1_bus_drv: tri-state driver pair for the C1 data and ctrl lines.
// Ports:
//   data_oe, data_out  - enable and value for the data lines
//   ctrl_oe, ctrl_out  - enable and value for the ctrl lines
//   data, ctrl         - the shared C1 lines (high-Z when not enabled)
module c1_bus_drv #(
  parameter int DATA_W = 16,
  parameter int CMD_W  = 3
) (
  input  logic              data_oe,
  input  logic [DATA_W-1:0] data_out,
  input  logic              ctrl_oe,
  input  logic [CMD_W-1:0]  ctrl_out,
  inout  wire  [DATA_W-1:0] data,
  inout  wire  [CMD_W-1:0]  ctrl
);

  assign data = data_oe ? data_out : {DATA_W{1'bz}};
  assign ctrl = ctrl_oe ? ctrl_out : {CMD_W{1'bz}};

endmodule

// File: rtl/c1_bus_master.sv
// c1_bus_master: CPU-side requester in front of the L1 cache. Turns a
// single-cycle valid/ready request into a C1 bus transaction, waits for the
// cache response, gathers read data and returns one resp_valid pulse.
//
// Optional build macro C1_BUS_TIMEOUT_EN: bounds the response wait to
// TIMEOUT_CYC cycles and reports resp_err (timeout or NOP command). Without
// it the wait is unbounded and resp_err is constant 0.
//
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready/req_cmd/req_addr/req_wdata - CPU request
//   resp_valid/resp_rdata/resp_err                 - CPU response
//   addr (out), data/ctrl (tri-state inout)        - C1 bus
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | ready for a request, bus released
// CMD1    | ctrl=cmd, addr=tagset, write data low half on data
// CMD2    | ctrl=cmd, addr=offset, second write data beat
// TURN    | bus released for one turnaround cycle
// WAIT    | sampling ctrl for the cache response
// RD2     | capturing the upper half of a READ32
// DONE    | resp_valid pulse
module c1_bus_master
  import c1_bus_pkg::*;
#(
  parameter int TAGSET_W    = C1_TAGSET_W,
  parameter int OFFSET_W    = C1_OFFSET_W,
  parameter int DATA_W      = C1_DATA_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [C1_CMD_W-1:0]          req_cmd,
  input  logic [TAGSET_W+OFFSET_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0]          req_wdata,
  output logic                         resp_valid,
  output logic [2*DATA_W-1:0]          resp_rdata,
  output logic                         resp_err,
  output logic [TAGSET_W-1:0]          addr,
  inout  wire  [DATA_W-1:0]            data,
  inout  wire  [C1_CMD_W-1:0]          ctrl
);

  c1_state_e state_q, state_d;

  logic [C1_CMD_W-1:0] cmd_q;
  logic [TAGSET_W-1:0] tagset_q;
  logic [OFFSET_W-1:0] offset_q;
  logic [2*DATA_W-1:0] wdata_q;
  logic [2*DATA_W-1:0] rdata_q;

  logic                data_oe;
  logic [DATA_W-1:0]   data_out;
  logic                ctrl_oe;
  logic                accept;
  logic                rd_lo_narrow;
  logic                rd_lo_wide;
  logic                rd_hi;
  logic                resp_seen;

`ifdef C1_BUS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q;
  logic             tmo_fire;
  logic             err_q;
`endif

  assign accept    = req_valid && (state_q == ST_IDLE);
  assign resp_seen = (ctrl == C1_RESPONSE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    ctrl_oe      = 1'b0;
    data_oe      = 1'b0;
    data_out     = wdata_q[DATA_W-1:0];
    addr         = {{(TAGSET_W-OFFSET_W){1'b0}}, offset_q};
    rd_lo_narrow = 1'b0;
    rd_lo_wide   = 1'b0;
    rd_hi        = 1'b0;
`ifdef C1_BUS_TIMEOUT_EN
    tmo_fire     = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        addr      = '0;
        if (req_valid) begin
          // NOP never touches the bus; it is answered straight away.
          state_d = (req_cmd == C1_NOP) ? ST_DONE : ST_CMD1;
        end
      end
      ST_CMD1: begin
        ctrl_oe = 1'b1;
        addr    = tagset_q;
        data_oe = is_write(cmd_q);
        state_d = ST_CMD2;
      end
      ST_CMD2: begin
        ctrl_oe  = 1'b1;
        data_oe  = is_write(cmd_q);
        data_out = (cmd_q == C1_WRITE32) ? wdata_q[2*DATA_W-1:DATA_W]
                                         : wdata_q[DATA_W-1:0];
        state_d  = ST_TURN;
      end
      ST_TURN: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A response on the same edge as the timeout takes priority.
        if (resp_seen) begin
          if (cmd_q == C1_READ32) begin
            rd_lo_wide = 1'b1;
            state_d    = ST_RD2;
          end else begin
            rd_lo_narrow = (cmd_q == C1_READ8) || (cmd_q == C1_READ16);
            state_d      = ST_DONE;
          end
        end
`ifdef C1_BUS_TIMEOUT_EN
        else if (tmo_q == '0) begin
          tmo_fire = 1'b1;
          state_d  = ST_DONE;
        end
`endif
      end
      ST_RD2: begin
        rd_hi   = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        resp_valid = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_q    <= C1_NOP;
      tagset_q <= '0;
      offset_q <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      if (accept) begin
        cmd_q    <= req_cmd;
        tagset_q <= req_addr[TAGSET_W+OFFSET_W-1:OFFSET_W];
        offset_q <= req_addr[OFFSET_W-1:0];
        wdata_q  <= req_wdata;
      end
      if (rd_lo_narrow) begin
        if (cmd_q == C1_READ8) begin
          rdata_q <= {{(2*DATA_W-8){1'b0}}, data[7:0]};
        end else begin
          rdata_q <= {{DATA_W{1'b0}}, data};
        end
      end else if (rd_lo_wide) begin
        rdata_q[DATA_W-1:0] <= data;
      end else if (rd_hi) begin
        rdata_q[2*DATA_W-1:DATA_W] <= data;
      end
`ifdef C1_BUS_TIMEOUT_EN
      else if (tmo_fire) begin
        rdata_q <= '0;
      end
`endif
    end
  end

`ifdef C1_BUS_TIMEOUT_EN
  // Down-counter loaded in TURN so the first WAIT cycle sees TIMEOUT_CYC-1;
  // terminal count 0 gives exactly TIMEOUT_CYC WAIT cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == ST_TURN) begin
        tmo_q <= TMO_W'(TIMEOUT_CYC - 1);
      end else if ((state_q == ST_WAIT) && (tmo_q != '0)) begin
        tmo_q <= tmo_q - 1'b1;
      end
      if (accept) begin
        err_q <= (req_cmd == C1_NOP);
      end else if (tmo_fire) begin
        err_q <= 1'b1;
      end
    end
  end

  assign resp_err = err_q && (state_q == ST_DONE);
`else
  assign resp_err = 1'b0;
`endif

  assign resp_rdata = rdata_q;

  c1_bus_drv #(
    .DATA_W (DATA_W),
    .CMD_W  (C1_CMD_W)
  ) u_drv (
    .data_oe  (data_oe),
    .data_out (data_out),
    .ctrl_oe  (ctrl_oe),
    .ctrl_out (cmd_q),
    .data     (data),
    .ctrl     (ctrl)
  );

endmodule

// File: tb/tb_c1_bus_master.sv
module tb_c1_bus_master;
  import c1_bus_pkg::*;

  localparam int TAGSET_W    = 14;
  localparam int OFFSET_W    = 4;
  localparam int DATA_W      = 16;
  localparam int TIMEOUT_CYC = 8;

`ifdef C1_BUS_TIMEOUT_EN
  localparam logic NOP_ERR = 1'b1;
`else
  localparam logic NOP_ERR = 1'b0;
`endif

  logic                         clk = 1'b0;
  logic                         reset = 1'b0;
  logic                         req_valid;
  logic                         req_ready;
  logic [2:0]                   req_cmd;
  logic [TAGSET_W+OFFSET_W-1:0] req_addr;
  logic [2*DATA_W-1:0]          req_wdata;
  logic                         resp_valid;
  logic [2*DATA_W-1:0]          resp_rdata;
  logic                         resp_err;
  logic [TAGSET_W-1:0]          addr;
  wire  [DATA_W-1:0]            data;
  wire  [2:0]                   ctrl;

  logic              tb_data_oe = 1'b0;
  logic [DATA_W-1:0] tb_data = '0;
  logic              tb_ctrl_oe = 1'b0;
  logic [2:0]        tb_ctrl = 3'd0;

  assign data = tb_data_oe ? tb_data : {DATA_W{1'bz}};
  assign ctrl = tb_ctrl_oe ? tb_ctrl : 3'bzzz;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  c1_bus_master #(
    .TAGSET_W    (TAGSET_W),
    .OFFSET_W    (OFFSET_W),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_cmd    (req_cmd),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .addr       (addr),
    .data       (data),
    .ctrl       (ctrl)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] cmd, input logic [17:0] a, input logic [31:0] wd);
    req_valid = 1'b1;
    req_cmd   = cmd;
    req_addr  = a;
    req_wdata = wd;
    step();
    req_valid = 1'b0;
  endtask

  // Cache drives RESPONSE (and optionally data) for one WAIT edge.
  task automatic respond(input logic [15:0] d, input logic d_en);
    tb_ctrl    = C1_RESPONSE;
    tb_ctrl_oe = 1'b1;
    tb_data    = d;
    tb_data_oe = d_en;
    step();
    tb_ctrl_oe = 1'b0;
    tb_data_oe = 1'b0;
  endtask

  initial begin
    req_valid = 1'b0;
    req_cmd   = 3'd0;
    req_addr  = '0;
    req_wdata = '0;
    #3;
    chk("rst_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_addr", addr, 0);
    chk("rst_data_oe", dut.u_drv.data_oe, 0);
    chk("rst_ctrl_oe", dut.u_drv.ctrl_oe, 0);
    step();
    reset = 1'b1;
    step();

    // WRITE8 at address 0
    send(C1_WRITE8, 18'h00000, 32'h0000AA11);
    chk("w8_c1_ctrl", ctrl, 5);
    chk("w8_c1_addr", addr, 0);
    chk("w8_c1_data", data, 16'hAA11);
    chk("w8_c1_ready", req_ready, 0);
    step();
    chk("w8_c2_ctrl", ctrl, 5);
    chk("w8_c2_addr", addr, 0);
    chk("w8_c2_data", data, 16'hAA11);
    step();
    chk("w8_turn_data_oe", dut.u_drv.data_oe, 0);
    chk("w8_turn_ctrl_oe", dut.u_drv.ctrl_oe, 0);
    step();
    chk("w8_wait1_valid", resp_valid, 0);
    step();
    chk("w8_wait2_valid", resp_valid, 0);
    respond(16'h0000, 1'b0);
    chk("w8_resp_valid", resp_valid, 1);
    chk("w8_resp_err", resp_err, 0);
    chk("w8_rdata", resp_rdata, 0);
    step();
    chk("w8_idle_valid", resp_valid, 0);
    chk("w8_idle_ready", req_ready, 1);

    // WRITE32, offset 3
    send(C1_WRITE32, 18'h00003, 32'h33334444);
    chk("w32_c1_ctrl", ctrl, 7);
    chk("w32_c1_addr", addr, 0);
    chk("w32_c1_data", data, 16'h4444);
    step();
    chk("w32_c2_addr", addr, 3);
    chk("w32_c2_data", data, 16'h3333);
    step();
    chk("w32_turn_ctrl_oe", dut.u_drv.ctrl_oe, 0);
    chk("w32_turn_addr", addr, 3);
    step();
    step();
    chk("w32_no_self_resp", resp_valid, 0);
    respond(16'h0000, 1'b0);
    chk("w32_resp_valid", resp_valid, 1);
    chk("w32_resp_err", resp_err, 0);
    step();

    // READ32: 0x3333 then 0x2222
    send(C1_READ32, 18'h00000, 32'h0);
    chk("r32_c1_ctrl", ctrl, 3);
    chk("r32_c1_data_oe", dut.u_drv.data_oe, 0);
    step();
    chk("r32_c2_data_oe", dut.u_drv.data_oe, 0);
    step();
    step();
    tb_ctrl = C1_RESPONSE; tb_ctrl_oe = 1'b1;
    tb_data = 16'h3333;    tb_data_oe = 1'b1;
    step();
    tb_ctrl_oe = 1'b0;
    tb_data    = 16'h2222;
    chk("r32_rd2_valid", resp_valid, 0);
    step();
    tb_data_oe = 1'b0;
    chk("r32_resp_valid", resp_valid, 1);
    chk("r32_rdata", resp_rdata, 32'h22223333);
    step();

    // READ8 offset 6, READ16 offset 4
    send(C1_READ8, 18'h00006, 32'h0);
    step();
    chk("r8_c2_addr", addr, 6);
    step();
    step();
    respond(16'hBEEF, 1'b1);
    chk("r8_resp_valid", resp_valid, 1);
    chk("r8_rdata", resp_rdata, 32'h000000EF);
    step();
    send(C1_READ16, 18'h00004, 32'h0);
    step();
    chk("r16_c2_addr", addr, 4);
    step();
    step();
    respond(16'hBEEF, 1'b1);
    chk("r16_rdata", resp_rdata, 32'h0000BEEF);
    step();

    // WRITE16 at max address: data low half both beats, rdata untouched
    send(C1_WRITE16, 18'h3FFFF, 32'h55551234);
    chk("w16_c1_addr", addr, 14'h3FFF);
    chk("w16_c1_data", data, 16'h1234);
    step();
    chk("w16_c2_addr", addr, 4'hF);
    chk("w16_c2_data", data, 16'h1234);
    step();
    step();
    respond(16'h0000, 1'b0);
    chk("w16_resp_valid", resp_valid, 1);
    chk("w16_rdata_kept", resp_rdata, 32'h0000BEEF);
    step();

    // Reset during CMD1 releases the bus at once
    send(C1_WRITE32, 18'h00001, 32'h12345678);
    reset = 1'b0;
    #1;
    chk("rst_cmd1_ctrl_oe", dut.u_drv.ctrl_oe, 0);
    chk("rst_cmd1_data_oe", dut.u_drv.data_oe, 0);
    chk("rst_cmd1_ready", req_ready, 1);
    step();
    reset = 1'b1;
    step();

    // INVALIDATE_LINE with reset during WAIT
    send(C1_INVALIDATE_LINE, 18'h00800, 32'h0);
    chk("inv_c1_addr", addr, 14'h0080);
    chk("inv_c1_ctrl", ctrl, 4);
    chk("inv_c1_data_oe", dut.u_drv.data_oe, 0);
    step();
    chk("inv_c2_addr", addr, 0);
    step();
    step();
    step();
    reset = 1'b0;
    #1;
    chk("inv_rst_ctrl_oe", dut.u_drv.ctrl_oe, 0);
    chk("inv_rst_data_oe", dut.u_drv.data_oe, 0);
    chk("inv_rst_ready", req_ready, 1);
    chk("inv_rst_valid", resp_valid, 0);
    step();
    reset = 1'b1;
    step();
    chk("inv_after_rst_valid1", resp_valid, 0);
    step();
    chk("inv_after_rst_valid2", resp_valid, 0);
    chk("inv_after_rst_ready", req_ready, 1);
    send(C1_INVALIDATE_LINE, 18'h00800, 32'h0);
    step();
    step();
    step();
    respond(16'h0000, 1'b0);
    chk("inv_resp_valid", resp_valid, 1);
    chk("inv_resp_err", resp_err, 0);
    step();

    // NOP: answered the next cycle, no bus activity
    send(C1_NOP, 18'h12345, 32'h0);
    chk("nop_resp_valid", resp_valid, 1);
    chk("nop_resp_err", resp_err, NOP_ERR);
    chk("nop_ctrl_oe", dut.u_drv.ctrl_oe, 0);
    step();
    chk("nop_idle_valid", resp_valid, 0);
    chk("nop_idle_ready", req_ready, 1);

`ifdef C1_BUS_TIMEOUT_EN
    // No response: timeout after exactly TIMEOUT_CYC WAIT cycles
    send(C1_READ16, 18'h00000, 32'h0);
    step();
    step();
    step();
    for (int i = 0; i < TIMEOUT_CYC - 1; i++) begin
      chk("tmo_wait_valid", resp_valid, 0);
      step();
    end
    chk("tmo_wait_last_valid", resp_valid, 0);
    step();
    chk("tmo_resp_valid", resp_valid, 1);
    chk("tmo_resp_err", resp_err, 1);
    chk("tmo_rdata", resp_rdata, 0);
    step();

    // Response on the timeout edge wins
    send(C1_READ16, 18'h00000, 32'h0);
    step();
    step();
    step();
    for (int i = 0; i < TIMEOUT_CYC - 1; i++) begin
      step();
    end
    respond(16'hABCD, 1'b1);
    chk("tie_resp_valid", resp_valid, 1);
    chk("tie_resp_err", resp_err, 0);
    chk("tie_rdata", resp_rdata, 32'h0000ABCD);
    step();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
